// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, register address width
// and the field layout of a fetched {inst, pc} payload.
package cpu_pkg;

   localparam int unsigned CPU_XLEN      = 32;
   localparam int unsigned REG_ADDR_W    = 5;
   localparam int unsigned CPU_PAYLOAD_W = 64;

   // Payload field offsets within {inst, pc}
   localparam int unsigned INST_MSB = 63;
   localparam int unsigned INST_LSB = 32;
   localparam int unsigned PC_MSB   = 31;
   localparam int unsigned PC_LSB   = 0;

   typedef struct packed {
      logic [INST_MSB-INST_LSB:0] inst;
      logic [PC_MSB-PC_LSB:0]     pc;
   } payload_t;

endpackage

// File: rtl/flush_fifo.sv
// Circular payload buffer with a redirect flush. A flush keeps only the
// head popped in the same cycle; every other entry and any same-cycle push
// are dropped, leaving the buffer empty with equal pointers.
module flush_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned PAYLOAD_W = CPU_PAYLOAD_W
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 flush,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 in_ready,
   output logic                 head_valid,
   output logic [PAYLOAD_W-1:0] head_payload
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PAYLOAD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr_nxt;
   logic [CNT_W-1:0]     count;

   // Full is judged on the registered count only, so a pop never reopens
   // in_ready within the same cycle.
   assign in_ready     = resetn & (count != FULL_CNT);
   assign head_valid   = (count != '0);
   assign head_payload = head_valid ? mem[rd_ptr] : '0;
   assign rd_ptr_nxt   = rd_ptr + PTR_W'(pop);

   // Pointer and occupancy update; flush collapses both pointers past the popped head.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= rd_ptr_nxt;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage write; a push that coincides with a flush is discarded.
   always_ff @(posedge clk) begin
      if (resetn && push && !flush) begin
         mem[wr_ptr] <= in_payload;
      end
   end

endmodule

// File: rtl/id_operand_queue.sv
// Decode-stage front end: buffers fetched payloads, presents the head to the
// decoder, resolves its two source operands through a priority forwarding
// network, stalls on pending producers and counts hazard-stall cycles.
module id_operand_queue
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN      = CPU_XLEN,
   parameter int unsigned PAYLOAD_W = CPU_PAYLOAD_W,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned NUM_FWD   = 3
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PAYLOAD_W-1:0]          in_payload,
   output logic [PAYLOAD_W-1:0]          head_payload,
   input  logic [REG_ADDR_W-1:0]         rs1_addr,
   input  logic [REG_ADDR_W-1:0]         rs2_addr,
   input  logic                          need_rs1,
   input  logic                          need_rs2,
   input  logic [XLEN-1:0]               rf_rdata1,
   input  logic [XLEN-1:0]               rf_rdata2,
   input  logic [NUM_FWD-1:0]            fwd_we,
   input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_waddr,
   input  logic [XLEN*NUM_FWD-1:0]       fwd_wdata,
   input  logic [NUM_FWD-1:0]            fwd_pending,
   output logic [XLEN-1:0]               rs1_value,
   output logic [XLEN-1:0]               rs2_value,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PAYLOAD_W-1:0]          out_payload,
   input  logic                          flush,
   output logic [31:0]                   stall_cycles
);

   logic hv;
   logic push;
   logic pop;
   logic hazard;
   logic rs1_hit;
   logic rs2_hit;
   logic rs1_pend;
   logic rs2_pend;

   assign push        = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign hazard      = (need_rs1 & rs1_pend) | (need_rs2 & rs2_pend);
   assign out_valid   = hv & ~hazard;
   assign out_payload = head_payload;

   flush_fifo #(
      .DEPTH     (DEPTH),
      .PAYLOAD_W (PAYLOAD_W)
   ) u_fifo (
      .clk          (clk),
      .resetn       (resetn),
      .push         (push),
      .pop          (pop),
      .flush        (flush),
      .in_payload   (in_payload),
      .in_ready     (in_ready),
      .head_valid   (hv),
      .head_payload (head_payload)
   );

   // Priority forwarding: the first (youngest) matching source wins; its
   // pending flag alone decides the stall, so older pending matches are hidden.
   always_comb begin
      rs1_value = rf_rdata1;
      rs2_value = rf_rdata2;
      rs1_hit   = 1'b0;
      rs2_hit   = 1'b0;
      rs1_pend  = 1'b0;
      rs2_pend  = 1'b0;
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
         if (!rs1_hit && fwd_we[i] && (rs1_addr != '0) &&
             (fwd_waddr[i*REG_ADDR_W +: REG_ADDR_W] == rs1_addr)) begin
            rs1_hit   = 1'b1;
            rs1_value = fwd_wdata[i*XLEN +: XLEN];
            rs1_pend  = fwd_pending[i];
         end
         if (!rs2_hit && fwd_we[i] && (rs2_addr != '0) &&
             (fwd_waddr[i*REG_ADDR_W +: REG_ADDR_W] == rs2_addr)) begin
            rs2_hit   = 1'b1;
            rs2_value = fwd_wdata[i*XLEN +: XLEN];
            rs2_pend  = fwd_pending[i];
         end
      end
   end

   // Saturating count of cycles where a valid head is held by a hazard.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stall_cycles <= '0;
      end else if (hv && hazard && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_id_operand_queue.sv
// Self-checking bench for id_operand_queue: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model.
module tb_id_operand_queue;

   localparam int DEPTH = 2;
   localparam int NF    = 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_payload;
   logic [63:0]   head_payload;
   logic [4:0]    rs1_addr, rs2_addr;
   logic          need_rs1, need_rs2;
   logic [31:0]   rf_rdata1, rf_rdata2;
   logic [NF-1:0] fwd_we;
   logic [5*NF-1:0]  fwd_waddr;
   logic [32*NF-1:0] fwd_wdata;
   logic [NF-1:0] fwd_pending;
   logic [31:0]   rs1_value, rs2_value;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_payload;
   logic          flush;
   logic [31:0]   stall_cycles;

   always #5 clk = ~clk;

   id_operand_queue #(
      .XLEN      (32),
      .PAYLOAD_W (64),
      .DEPTH     (DEPTH),
      .NUM_FWD   (NF)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_payload   (in_payload),
      .head_payload (head_payload),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .need_rs1     (need_rs1),
      .need_rs2     (need_rs2),
      .rf_rdata1    (rf_rdata1),
      .rf_rdata2    (rf_rdata2),
      .fwd_we       (fwd_we),
      .fwd_waddr    (fwd_waddr),
      .fwd_wdata    (fwd_wdata),
      .fwd_pending  (fwd_pending),
      .rs1_value    (rs1_value),
      .rs2_value    (rs2_value),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_payload  (out_payload),
      .flush        (flush),
      .stall_cycles (stall_cycles)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          checking = 1'b0;

   // Reference model state: buffered payloads in order, and the stall count
   logic [63:0] mq[$];
   logic [31:0] m_stall = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Operand lookup: youngest matching forwarding source, else register file
   function automatic void resolve(input logic [4:0] a, input logic [31:0] rf,
                                   output logic [31:0] v, output logic p);
      v = rf;
      p = 1'b0;
      if (a != 5'd0) begin
         for (int i = 0; i < NF; i++) begin
            if (fwd_we[i] && fwd_waddr[i*5 +: 5] == a) begin
               v = fwd_wdata[i*32 +: 32];
               p = fwd_pending[i];
               break;
            end
         end
      end
   endfunction

   function automatic void expect_now(output logic e_ir, output logic e_ov,
                                      output logic [63:0] e_head,
                                      output logic [31:0] e1, output logic [31:0] e2,
                                      output logic e_haz);
      logic p1, p2;
      resolve(rs1_addr, rf_rdata1, e1, p1);
      resolve(rs2_addr, rf_rdata2, e2, p2);
      e_haz  = (need_rs1 && p1) || (need_rs2 && p2);
      e_ir   = resetn && (mq.size() != DEPTH);
      e_head = (mq.size() != 0) ? mq[0] : 64'd0;
      e_ov   = (mq.size() != 0) && !e_haz;
   endfunction

   // Advance the model by one clock edge using the inputs the DUT sampled
   function automatic void model_step();
      logic ir, ov, haz;
      logic [63:0] hd;
      logic [31:0] v1, v2;
      if (!resetn) begin
         mq.delete();
         m_stall = 32'd0;
         return;
      end
      expect_now(ir, ov, hd, v1, v2, haz);
      if (mq.size() != 0 && haz && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) begin
         mq.delete();
      end else begin
         if (ov && out_ready) void'(mq.pop_front());
         if (in_valid && ir) mq.push_back(in_payload);
      end
   endfunction

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (checking) begin
         logic e_ir, e_ov, e_haz;
         logic [63:0] e_head;
         logic [31:0] e1, e2;
         expect_now(e_ir, e_ov, e_head, e1, e2, e_haz);
         chk("in_ready", 64'(in_ready), 64'(e_ir));
         chk("out_valid", 64'(out_valid), 64'(e_ov));
         chk("head_payload", head_payload, e_head);
         chk("out_payload", out_payload, e_head);
         chk("rs1_value", 64'(rs1_value), 64'(e1));
         chk("rs2_value", 64'(rs2_value), 64'(e2));
         chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
      end
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_fwd();
      fwd_we      = '0;
      fwd_waddr   = '0;
      fwd_wdata   = '0;
      fwd_pending = '0;
      need_rs1    = 1'b0;
      need_rs2    = 1'b0;
      rs1_addr    = 5'd0;
      rs2_addr    = 5'd0;
   endtask

   localparam logic [63:0] P_ADDI = 64'h02800421_1C000000;

   initial begin
      resetn     = 1'b0;
      in_valid   = 1'b0;
      in_payload = '0;
      out_ready  = 1'b0;
      flush      = 1'b0;
      rf_rdata1  = 32'h1111_1111;
      rf_rdata2  = 32'h2222_2222;
      clear_fwd();

      // Reset state
      cycle();
      checking = 1'b1;
      cycle();
      #3;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_head", head_payload, 64'd0);
      chk("rst_rs1", 64'(rs1_value), 64'h1111_1111);
      chk("rst_rs2", 64'(rs2_value), 64'h2222_2222);
      chk("rst_stall", 64'(stall_cycles), 64'd0);
      resetn = 1'b1;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);

      // Basic issue
      cycle();
      in_valid = 1'b1; in_payload = P_ADDI; out_ready = 1'b1;
      #3;
      chk("basic_empty_ov", 64'(out_valid), 64'd0);
      cycle();
      in_valid = 1'b0;
      #3;
      chk("basic_ov", 64'(out_valid), 64'd1);
      chk("basic_payload", out_payload, P_ADDI);
      cycle();
      #3;
      chk("basic_drained", 64'(out_valid), 64'd0);

      // Fill and backpressure
      cycle();
      out_ready = 1'b0; in_valid = 1'b1; in_payload = 64'hA1;
      cycle();
      in_payload = 64'hA2;
      cycle();
      in_payload = 64'hA3;
      #3;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      cycle();
      #3;
      chk("full_hold_ir", 64'(in_ready), 64'd0);
      chk("full_head", head_payload, 64'hA1);
      out_ready = 1'b1;
      #1;
      chk("full_pop_ir", 64'(in_ready), 64'd0);
      chk("full_pop_ov", 64'(out_valid), 64'd1);
      cycle();
      #3;
      chk("bp_head2", head_payload, 64'hA2);
      chk("bp_ir2", 64'(in_ready), 64'd1);
      cycle();
      in_valid = 1'b0;
      #3;
      chk("bp_head3", head_payload, 64'hA3);
      cycle();
      #3;
      chk("bp_done", 64'(out_valid), 64'd0);

      // Forwarding priority
      cycle();
      rs1_addr  = 5'd5;
      fwd_we    = 3'b111;
      fwd_waddr = {5'd5, 5'd5, 5'd5};
      fwd_wdata = {32'hC, 32'hB, 32'hA};
      #3;
      chk("fwd_idx0", 64'(rs1_value), 64'hA);
      cycle();
      fwd_we = 3'b110;
      #3;
      chk("fwd_idx1", 64'(rs1_value), 64'hB);
      cycle();
      rs1_addr = 5'd0;
      #3;
      chk("fwd_r0", 64'(rs1_value), 64'h1111_1111);
      cycle();
      clear_fwd();

      // Load-use stall
      in_valid = 1'b1; in_payload = 64'hB4; out_ready = 1'b0;
      cycle();
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      need_rs2    = 1'b1;
      rs2_addr    = 5'd7;
      fwd_we      = 3'b001;
      fwd_waddr   = {5'd0, 5'd0, 5'd7};
      fwd_wdata   = {32'h0, 32'h0, 32'hDEAD_BEEF};
      fwd_pending = 3'b001;
      #3;
      chk("lu_ov0", 64'(out_valid), 64'd0);
      cycle();
      #3;
      chk("lu_ov1", 64'(out_valid), 64'd0);
      chk("lu_stall1", 64'(stall_cycles), 64'd1);
      cycle();
      fwd_pending = 3'b000;
      #3;
      chk("lu_stall2", 64'(stall_cycles), 64'd2);
      chk("lu_issue", 64'(out_valid), 64'd1);
      chk("lu_value", 64'(rs2_value), 64'hDEAD_BEEF);
      cycle();
      clear_fwd();
      #3;
      chk("lu_done", 64'(out_valid), 64'd0);

      // Flush with pop
      out_ready = 1'b0; in_valid = 1'b1; in_payload = 64'hC5;
      cycle();
      in_payload = 64'hC6;
      cycle();
      in_payload = 64'hC7; flush = 1'b1; out_ready = 1'b1;
      #3;
      chk("fl_ov", 64'(out_valid), 64'd1);
      chk("fl_head", head_payload, 64'hC5);
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      #3;
      chk("fl_empty_ov", 64'(out_valid), 64'd0);
      chk("fl_empty_head", head_payload, 64'd0);
      chk("fl_ir", 64'(in_ready), 64'd1);

      // Reset mid-stream with a hazard
      out_ready = 1'b0; in_valid = 1'b1; in_payload = 64'hD8;
      cycle();
      in_payload = 64'hD9;
      cycle();
      in_valid    = 1'b0;
      need_rs1    = 1'b1;
      rs1_addr    = 5'd3;
      fwd_we      = 3'b001;
      fwd_waddr   = {5'd0, 5'd0, 5'd3};
      fwd_pending = 3'b001;
      cycle();
      #3;
      chk("rm_stall", 64'(stall_cycles), 64'd3);
      resetn = 1'b0;
      cycle();
      #3;
      chk("rm_ov", 64'(out_valid), 64'd0);
      chk("rm_stall0", 64'(stall_cycles), 64'd0);
      chk("rm_ir", 64'(in_ready), 64'd0);
      chk("rm_head", head_payload, 64'd0);
      resetn = 1'b1;
      #1;
      chk("rm_rel_ir", 64'(in_ready), 64'd1);
      clear_fwd();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cycle();
         resetn      = ($urandom_range(0, 63) != 0);
         in_valid    = ($urandom_range(0, 9) < 7);
         in_payload  = {$urandom(), $urandom()};
         out_ready   = ($urandom_range(0, 9) < 6);
         flush       = ($urandom_range(0, 15) == 0);
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         need_rs1    = 1'($urandom_range(0, 1));
         need_rs2    = 1'($urandom_range(0, 1));
         rf_rdata1   = $urandom();
         rf_rdata2   = $urandom();
         fwd_we      = 3'($urandom_range(0, 7));
         fwd_waddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7))};
         fwd_wdata   = {$urandom(), $urandom(), $urandom()};
         fwd_pending = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 3) == 0)};
      end
      cycle();
      cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/id_operand_queue.md
# id_operand_queue

Parametrised decode-stage front end. It sits between the fetch stage and the decode/issue logic. It buffers up to DEPTH fetched {inst, pc} payloads, presents the head entry to the decoder, and resolves the head's two source operands against the register file and NUM_FWD forwarding sources. It stalls issue on a pending (not-yet-available) producer and squashes younger entries on a redirect.

## Interface
- XLEN, 32: operand/data width.
- PAYLOAD_W, 64: fetched payload width ({inst, pc}).
- DEPTH, 2: buffer entries; power of two, ≥2.
- NUM_FWD, 3: forwarding sources; index 0 = youngest (EX), highest priority.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  fetch payload valid.
- in_ready  out  1  buffer can accept.
- in_payload  in  PAYLOAD_W  fetched {inst, pc}.
- head_payload  out  PAYLOAD_W  head entry, to the decoder.
- rs1_addr, rs2_addr  in  5 each  source registers decoded from head_payload.
- need_rs1, need_rs2  in  1 each  source actually read.
- rf_rdata1, rf_rdata2  in  XLEN each  register file read data.
- fwd_we  in  NUM_FWD  per-source write enable.
- fwd_waddr  in  5*NUM_FWD  per-source destination; slice i = [5i+4:5i].
- fwd_wdata  in  XLEN*NUM_FWD  per-source result.
- fwd_pending  in  NUM_FWD  result not yet available (load in EX, divider busy).
- rs1_value, rs2_value  out  XLEN each  resolved operands.
- out_valid  out  1  head issuable.
- out_ready  in  1  execute stage allows in.
- out_payload  out  PAYLOAD_W  equals head_payload.
- flush  in  1  redirect (branch taken): keep only the head transferred this cycle.
- stall_cycles  out  32  saturating count of hazard-stall cycles.

## Operation
- Buffer is a circular FIFO with rd_ptr, wr_ptr and a count in 0..DEPTH.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = resetn & (count != DEPTH). It does not depend on out_ready.
- Head valid (hv) = count != 0. head_payload = mem[rd_ptr], and is 0 when hv=0.
- Source matching, per source s ∈ {1, 2}: hit_i = fwd_we[i] & (waddr_i == rs_addr) & (rs_addr != 0). The lowest hit index wins.
  - value = winning fwd_wdata, or rf_rdata when there is no hit.
  - r0 always resolves to rf_rdata, with no forwarding and no stall.
- hazard = OR over s of need_s & winner_pending_s. A pending source at a higher index hidden by a non-pending lower-index hit does not stall.
- out_valid = hv & ~hazard.
- flush:
  - A pop in the same cycle completes normally.
  - All other entries and any same-cycle push are discarded; count becomes 0 and ptrs are equal.
  - in_ready is unaffected in the flush cycle.
- stall_cycles increments when hv & hazard. It saturates at 32'hFFFF_FFFF. It is cleared only by reset.

## Timing
- Reset (resetn=0 at a clk edge): count=0, ptrs=0, stall_cycles=0.
  - Outputs afterwards: out_valid=0, head_payload=0, rs1_value=rf_rdata1, rs2_value=rf_rdata2.
  - in_ready=0 while resetn=0. A push presented during reset is ignored.
- Push→issue latency: payload accepted at edge t is at the head and can issue in cycle t+1. There is no bypass.
- Operand resolution, hazard and out_valid are combinational from the current-cycle inputs.
- Full: in_ready=0. Simultaneous pop does not reopen in_ready in the same cycle (one-cycle bubble accepted).
- Empty with push: count 0→1, and out_valid can rise in the next cycle.
- Simultaneous push and pop, not full: count unchanged, both ptrs advance modulo DEPTH.
- out_payload must hold stable while out_valid & ~out_ready.
- Reset mid-operation: contents are discarded, and nothing is issued in the cycle after reset.

## Structure
- Shared package `cpu_pkg`:
  - XLEN default.
  - REG_ADDR_W = 5.
  - PAYLOAD_W default.
  - Payload field offsets: INST at [63:32], PC at [31:0].
- One sub-module: `flush_fifo` (DEPTH, PAYLOAD_W). It covers the ptrs, count, storage and flush.
- Forwarding priority mux and hazard logic stay in the top module, written as a for-loop over NUM_FWD.

## Test plan
- Basic issue: push 0x02800421_1C000000 (addi) in cycle 0, out_ready=1 → out_valid=1 in cycle 1 with the same payload, and count returns to 0.
- Fill and backpressure: DEPTH=2, out_ready=0, push 3 payloads → the 3rd sees in_ready=0 and is held. Raise out_ready → entries issue in order.
- Forwarding priority:
  - Setup: rs1_addr=5, fwd_we=3'b111, all waddr=5, wdata = 0xA/0xB/0xC, pending=0.
  - Check: rs1_value=0xA. With fwd_we=3'b110 → 0xB. With rs1_addr=0 → rf_rdata1.
- Load-use stall:
  - Setup: need_rs2=1, rs2_addr=7, fwd_we[0]=1, waddr0=7, pending[0]=1.
  - Check: out_valid=0 for 2 cycles and stall_cycles=2. Drop pending → issue with fwd_wdata0.
- Flush with pop: 2 entries buffered, in_valid=1, flush=1, out_ready=1 → the head issues, and the next cycle has count=0 and out_valid=0, with the incoming payload discarded.
- Reset mid-stream: assert resetn=0 with 2 entries and a hazard → next cycle out_valid=0, stall_cycles=0, in_ready=0. After release, in_ready=1.
